// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: buffers 16-bit pixels in a small show-ahead FIFO and
// issues one single-word write per pixel to sdram_ctrl at consecutive
// addresses starting at BASE_ADDR.
// Each frame is FRAME_WORDS long and ends with a one-cycle o_frame_done pulse.
// Optional build macro SDRAM_FRAME_WRITER_TESTPAT_EN: pushes the in-frame
// push index instead of i_pix_data (SDRAM bring-up readback pattern).
module sdram_frame_writer #(
  parameter int ADDR_W      = 15,
  parameter int FRAME_WORDS = 512,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_pix_valid,
  input  logic [15:0]       i_pix_data,
  input  logic              i_sdram_ready,
  input  logic              i_writing,
  output logic              o_sdram_en,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_datain,
  output logic              o_fifo_full,
  output logic              o_overflow,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // push counter must reach FRAME_WORDS itself, which may be 2^ADDR_W
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     FW_CNT   = CW'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [0:0] {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CW-1:0]     push_cnt_q, push_cnt_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       mem_q [FIFO_DEPTH];

  logic              fifo_empty, fifo_full, accept;
  logic              push_en;
  logic [PW-1:0]     push_slot;
  logic [15:0]       push_data;
  logic [CW-1:0]     pcnt_base;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign accept     = (state_q == WRITE) && !fifo_empty &&
                      i_sdram_ready && !i_writing;

  // Next-state: frame start/abort, push/drop, pop on acceptance, frame end.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    idx_d        = idx_q;
    push_cnt_d   = push_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    push_en      = 1'b0;
    push_slot    = wr_ptr_q[PW-1:0];
    pcnt_base    = push_cnt_q;

    if (i_frame_start) begin
      // New frame (or abort of the current one): flush, then the same-cycle
      // pixel, if any, becomes word 0.
      state_d    = WRITE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      idx_d      = '0;
      push_cnt_d = '0;
      overflow_d = 1'b0;
      pcnt_base  = '0;
      if (i_pix_valid) begin
        push_en    = 1'b1;
        push_slot  = '0;
        wr_ptr_d   = {{PW{1'b0}}, 1'b1};
        push_cnt_d = CW'(1);
      end
    end else if (state_q == WRITE) begin
      if (accept) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        idx_d    = idx_q + 1'b1;
      end
      if (i_pix_valid) begin
        if (push_cnt_q == FW_CNT) begin
          // frame already has all its pixels: discard quietly
        end else if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          push_en    = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          push_cnt_d = push_cnt_q + 1'b1;
        end
      end
      if (accept && (idx_q == LAST_IDX)) begin
        state_d      = IDLE;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        idx_d        = '0;
        frame_done_d = 1'b1;
      end
    end

`ifdef SDRAM_FRAME_WRITER_TESTPAT_EN
    push_data = 16'(pcnt_base);
`else
    push_data = i_pix_data;
`endif
  end

`ifdef SDRAM_FRAME_WRITER_TESTPAT_EN
  logic unused_pix;
  assign unused_pix = ^i_pix_data;
`endif

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= '0;
      push_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      push_cnt_q   <= push_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are don't-care until written, reads are gated.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[push_slot] <= push_data;
  end

  assign o_sdram_en   = (state_q == WRITE) && !fifo_empty;
  assign o_rw         = 1'b0;
  assign o_addr       = BASE + idx_q;
  assign o_datain     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q[PW-1:0]];
  assign o_fifo_full  = fifo_full;
  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q == WRITE);

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Bench for sdram_frame_writer: three instances (8-word frame, 20-word frame
// for FIFO backpressure, 4-bit address wrap). Stimulus pushes expected
// writes into a scoreboard; a negedge monitor pops on every accepted write.
module tb_sdram_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  fs, pv;
  logic [15:0] pd;
  logic        rdy, wrt;

  wire  [2:0]        en, rw, full, ovf, done, busy;
  wire  [2:0][14:0]  adr;
  wire  [2:0][15:0]  din;
  wire  [3:0]        adr_c;
  assign adr[2] = {11'd0, adr_c};

  sdram_frame_writer #(.ADDR_W(15), .FRAME_WORDS(8), .BASE_ADDR(0), .FIFO_DEPTH(16)) u_a (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs[0]), .i_pix_valid(pv[0]),
    .i_pix_data(pd), .i_sdram_ready(rdy), .i_writing(wrt),
    .o_sdram_en(en[0]), .o_rw(rw[0]), .o_addr(adr[0]), .o_datain(din[0]),
    .o_fifo_full(full[0]), .o_overflow(ovf[0]), .o_frame_done(done[0]), .o_busy(busy[0]));

  sdram_frame_writer #(.ADDR_W(15), .FRAME_WORDS(20), .BASE_ADDR(0), .FIFO_DEPTH(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs[1]), .i_pix_valid(pv[1]),
    .i_pix_data(pd), .i_sdram_ready(rdy), .i_writing(wrt),
    .o_sdram_en(en[1]), .o_rw(rw[1]), .o_addr(adr[1]), .o_datain(din[1]),
    .o_fifo_full(full[1]), .o_overflow(ovf[1]), .o_frame_done(done[1]), .o_busy(busy[1]));

  sdram_frame_writer #(.ADDR_W(4), .FRAME_WORDS(4), .BASE_ADDR(14), .FIFO_DEPTH(16)) u_c (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs[2]), .i_pix_valid(pv[2]),
    .i_pix_data(pd), .i_sdram_ready(rdy), .i_writing(wrt),
    .o_sdram_en(en[2]), .o_rw(rw[2]), .o_addr(adr_c), .o_datain(din[2]),
    .o_fifo_full(full[2]), .o_overflow(ovf[2]), .o_frame_done(done[2]), .o_busy(busy[2]));

  typedef struct {
    int          k;
    logic [14:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt[3] = '{0, 0, 0};

  function automatic logic [15:0] expd(input logic [15:0] pix, input int idx);
`ifdef SDRAM_FRAME_WRITER_TESTPAT_EN
    return 16'(idx);
`else
    return pix;
`endif
  endfunction

  function automatic int base_of(input int k);
    return (k == 2) ? 14 : 0;
  endfunction

  function automatic int mask_of(input int k);
    return (k == 2) ? 15 : 32767;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_en%0d", k),   32'(en[k]), 0);
    chk($sformatf("rst_rw%0d", k),   32'(rw[k]), 0);
    chk($sformatf("rst_addr%0d", k), 32'(adr[k]), base_of(k));
    chk($sformatf("rst_din%0d", k),  32'(din[k]), 0);
    chk($sformatf("rst_full%0d", k), 32'(full[k]), 0);
    chk($sformatf("rst_ovf%0d", k),  32'(ovf[k]), 0);
    chk($sformatf("rst_done%0d", k), 32'(done[k]), 0);
    chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
  endtask

  task automatic push(input int k, input logic [15:0] data, input int idx, input bit track);
    exp_t e;
    pv[k] = 1'b1;
    pd    = data;
    if (track) begin
      e.k = k;
      e.a = 15'((base_of(k) + idx) & mask_of(k));
      e.d = expd(data, idx);
      sb.push_back(e);
    end
    cyc();
    pv[k] = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain (and optionally the frame to end).
  task automatic wait_q(input string name, input int k, input bit need_idle);
    int n = 0;
    while (n < 200 && !(sb.size() == 0 && (!need_idle || !busy[k]))) begin
      cyc();
      n++;
    end
    chk(name, 32'(sb.size() == 0 && (!need_idle || !busy[k])), 1);
    cyc();
  endtask

  // Monitor: every accepted write must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (done[k]) done_cnt[k]++;
        if (en[k] && rdy && !wrt) begin
          total++;
          if (sb.size() == 0 || sb[0].k != k) begin
            bad++;
            $display("FAIL wr_unexpected inst=%0d addr=%0h data=%0h required=none",
                     k, adr[k], din[k]);
          end else begin
            me = sb.pop_front();
            if (adr[k] !== me.a || din[k] !== me.d || rw[k] !== 1'b0) begin
              bad++;
              $display("FAIL wr_data inst=%0d actual addr=%0h data=%0h rw=%0b required addr=%0h data=%0h rw=0",
                       k, adr[k], din[k], rw[k], me.a, me.d);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; fs = '0; pv = '0; pd = '0; rdy = 1'b1; wrt = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk_reset(k);

    // basic 8-word frame
    fs[0] = 1'b1; cyc(); fs[0] = 1'b0;
    chk("basic_busy", 32'(busy[0]), 1);
    chk("basic_en_empty", 32'(en[0]), 0);
    for (int i = 0; i < 8; i++) begin
      push(0, 16'(16'h1000 + i), i, 1'b1);
      if (i == 0) begin
        chk("lat_en", 32'(en[0]), 1);
        chk("lat_din", 32'(din[0]), 32'(expd(16'h1000, 0)));
      end
    end
    wait_q("basic_finish", 0, 1'b1);
    chk("basic_done_cnt", done_cnt[0], 1);
    chk("basic_busy_end", 32'(busy[0]), 0);
    chk("basic_full_end", 32'(full[0]), 0);
    pv[0] = 1'b1; pd = 16'h1111; cyc(); cyc(); pv[0] = 1'b0;
    chk("idle_ignore_en", 32'(en[0]), 0);
    chk("idle_ignore_busy", 32'(busy[0]), 0);

    // backpressure with overflow
    wrt = 1'b1;
    fs[1] = 1'b1; cyc(); fs[1] = 1'b0;
    for (int i = 0; i < 16; i++) push(1, 16'(16'h2000 + i), i, 1'b1);
    chk("bp_full", 32'(full[1]), 1);
    chk("bp_ovf_before", 32'(ovf[1]), 0);
    push(1, 16'h2FFF, 0, 1'b0);
    chk("bp_ovf", 32'(ovf[1]), 1);
    chk("bp_full_hold", 32'(full[1]), 1);
    wrt = 1'b0;
    wait_q("bp_drain", 1, 1'b0);
    chk("bp_full_after", 32'(full[1]), 0);
    chk("bp_ovf_sticky", 32'(ovf[1]), 1);
    chk("bp_busy", 32'(busy[1]), 1);
    for (int i = 16; i < 20; i++) push(1, 16'(16'h2000 + i), i, 1'b1);
    wait_q("bp_finish", 1, 1'b1);
    chk("bp_done_cnt", done_cnt[1], 1);

    // abort after 3 accepted words, restart with same-cycle pixel
    fs[0] = 1'b1; cyc(); fs[0] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 16'(16'h3000 + i), i, 1'b1);
    wait_q("abort_first3", 0, 1'b0);
    fs[0] = 1'b1;
    push(0, 16'hBEEF, 0, 1'b1);
    fs[0] = 1'b0;
    chk("abort_en", 32'(en[0]), 1);
    chk("abort_addr", 32'(adr[0]), 0);
    chk("abort_din", 32'(din[0]), 32'(expd(16'hBEEF, 0)));
    chk("abort_ovf_clr", 32'(ovf[0]), 0);
    cyc();
    chk("abort_no_done", done_cnt[0], 1);
    for (int i = 1; i < 8; i++) push(0, 16'(16'h3100 + i), i, 1'b1);
    wait_q("abort_finish", 0, 1'b1);
    chk("abort_done_cnt", done_cnt[0], 2);

    // reset mid-frame with 5 words queued
    fs[0] = 1'b1; cyc(); fs[0] = 1'b0;
    wrt = 1'b1;
    for (int i = 0; i < 5; i++) push(0, 16'(16'h4000 + i), i, 1'b0);
    chk("midrst_en_before", 32'(en[0]), 1);
    rst = 1'b1; cyc();
    chk_reset(0);
    rst = 1'b0; wrt = 1'b0;
    pv[0] = 1'b1; pd = 16'h4444; cyc(); cyc(); pv[0] = 1'b0;
    chk("midrst_ignore_en", 32'(en[0]), 0);
    chk("midrst_ignore_busy", 32'(busy[0]), 0);
    chk("midrst_done_cnt", done_cnt[0], 2);

    // address wrap: 14, 15, 0, 1
    fs[2] = 1'b1; cyc(); fs[2] = 1'b0;
    for (int i = 0; i < 4; i++) push(2, 16'(16'h5000 + i), i, 1'b1);
    wait_q("wrap_finish", 2, 1'b1);
    chk("wrap_done_cnt", done_cnt[2], 1);
    chk("wrap_addr_idle", 32'(adr[2]), 14);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
